maxpool3x3_s2: RTL and testbench
================================

Name: maxpool3x3_s2

Overview:
- Single-channel 3x3 max-pool, stride 2, no padding, on a raster-order pixel stream with valid qualification.
- Sits directly downstream of the 96-to-32 channel adder stage. One instance per adder output channel (32 in parallel), each consuming that channel's pxl_out and valid_out.
- Reduces a WIDTH x HEIGHT plane (149x149) to ((WIDTH-3)/2+1) x ((HEIGHT-3)/2+1), which is 74x74.

Parameters:
- WIDTH, 149, pixels per input row (>=3, odd).
- HEIGHT, 149, rows per input frame (>=3, odd).
- DATA_WIDTH, 32, pixel width; signed two's complement.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  pxl_in carries a pixel this cycle
- pxl_in  input  DATA_WIDTH  input pixel, raster order (row-major)
- pxl_out  output  DATA_WIDTH  pooled pixel
- valid_out  output  1  pxl_out valid, single-cycle pulse per pooled pixel
- frame_done  output  1  one-cycle pulse together with the last pooled pixel of a frame

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - Reset clears pxl_out=0, valid_out=0, frame_done=0, col=0, row=0, and all pipeline valid flags.
  - Line-buffer RAM contents are not reset.
- No backpressure. valid_in may have arbitrary gaps. Nothing advances on cycles with valid_in=0. Output is identical for gapped and back-to-back input.
- Counters:
  - col counts 0..WIDTH-1. At WIDTH-1 it wraps to 0 and row increments.
  - row counts 0..HEIGHT-1. On (row=HEIGHT-1, col=WIDTH-1) both wrap to 0 and the next frame starts with no gap needed.
- Line buffers:
  - lb1 holds row r-1 and lb0 holds row r-2, each WIDTH entries, addressed by col.
  - On each accepted pixel: read lb0[col] and lb1[col], write lb0[col]<=lb1[col] and lb1[col]<=pxl_in in the same cycle (read-before-write).
- Stage 1 (registered): v = signed max(lb0[col], lb1[col], pxl_in), tagged with col, row and a valid flag.
- Horizontal window: the last three stage-1 values v, v_d1, v_d2 are kept in a shift register that advances only on a stage-1 valid.
- Stage 2 (registered output): pxl_out = signed max(v, v_d1, v_d2), with valid_out=1 only when the tagged row>=2, row even, col>=2 and col even.
  - Windows never straddle rows, because col>=2 is enforced.
- Latency: valid_out rises exactly 2 cycles after the valid_in that delivered a window's bottom-right pixel, provided valid_in stays high. Stage advancement is purely on accepted data.
- When valid_out=0, pxl_out holds its last value.
- frame_done is asserted with the window whose tagged position is (HEIGHT-1, WIDTH-1).
- Reset mid-frame: the pipeline flushes and no partial output is emitted. The next accepted pixel is treated as (0,0). Rows 0-1 of the new frame refill the line buffers, so stale contents are never used.
- Comparison is signed. Equal values yield that value; there is no tie ambiguity.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- When defined: pxl_in is clamped to 0 if negative before entering the line buffers and the max tree. Output is then never negative. Latency is unchanged (the clamp is combinational ahead of stage 1).
- When undefined: raw signed pooling.

Decomposition:
- Shared package (pool_pkg) holds:
  - a signed max2/max3 function parameterised by DATA_WIDTH;
  - localparams for stride (2) and kernel (3);
  - the counter width derivation $clog2(WIDTH) / $clog2(HEIGHT).
- One natural sub-module: pool_line_buffer. It is a WIDTH-deep, DATA_WIDTH single-port read-before-write RAM with enable and address, instantiated twice.

Test Plan:
- Ramp, WIDTH=HEIGHT=5, pixel = row*5+col, back-to-back -> exactly 4 valid_out pulses with values 12, 14, 22, 24. frame_done coincides with 24; first output 2 cycles after pixel (2,2).
- Same ramp with valid_in toggling every other cycle -> same 4 values in same order. Each output appears 2 accepted-pixel-cycles after its trigger pixel.
- Signed data, all pixels -7 except (3,3)=-2, 5x5 -> outputs -7, -7, -7, -2 without MAXPOOL_RELU_EN; 0, 0, 0, 0 with it.
- Two consecutive 5x5 ramp frames, second offset by +100 -> 8 outputs: 12, 14, 22, 24, 112, 114, 122, 124. frame_done pulses twice; no contamination from frame 1 into frame 2.
- Assert reset at pixel (3,1) of a frame, then stream a full fresh ramp -> no output during or after reset until the fresh frame's (2,2). Then exactly 12, 14, 22, 24.
- Default 149x149 random signed frame -> 5476 outputs matching a golden model. frame_done appears once, with the 5476th output.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared helpers for the 3x3 stride-2 max-pool: kernel geometry, counter sizing
// and signed max functions usable for any pixel width up to POOL_MAX_DW bits.
package pool_pkg;

    localparam int POOL_KERNEL = 3;
    localparam int POOL_STRIDE = 2;
    localparam int POOL_MAX_DW = 64;

    // Pixels are sign-extended into this type so one max tree serves every DATA_WIDTH.
    typedef logic signed [POOL_MAX_DW-1:0] pool_wide_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic pool_wide_t max2(input pool_wide_t a, input pool_wide_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pool_wide_t max3(input pool_wide_t a, input pool_wide_t b,
                                        input pool_wide_t c);
        return max2(max2(a, b), c);
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// WIDTH-deep single-port line buffer: combinational read of the addressed entry,
// write of the same entry on the clock edge (read-before-write).
module pool_line_buffer #(
    parameter int DEPTH      = 149,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 8
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic [AW-1:0]                addr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the RAM has no reset; rows 0-1 of every frame rewrite it before any window reads it.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/maxpool3x3_s2.sv
// Single-channel 3x3 stride-2 max-pool on a raster pixel stream, no padding.
// Optional build macro MAXPOOL_RELU_EN clamps negative input pixels to zero.
module maxpool3x3_s2
    import pool_pkg::*;
#(
    parameter int WIDTH      = 149,
    parameter int HEIGHT     = 149,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] pxl_in,
    output logic signed [DATA_WIDTH-1:0] pxl_out,
    output logic                         valid_out,
    output logic                         frame_done
);

    localparam int CW = cnt_width(WIDTH);
    localparam int RW = cnt_width(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(POOL_KERNEL - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(POOL_KERNEL - 1);

    function automatic pool_wide_t widen(input logic signed [DATA_WIDTH-1:0] x);
        return pool_wide_t'(x);
    endfunction

    logic [CW-1:0]                col;
    logic [RW-1:0]                row;
    logic signed [DATA_WIDTH-1:0] pxl_c;
    logic signed [DATA_WIDTH-1:0] lb0_q;
    logic signed [DATA_WIDTH-1:0] lb1_q;
    logic signed [DATA_WIDTH-1:0] col_max;

    logic                         s1_valid;
    logic signed [DATA_WIDTH-1:0] s1_v;
    logic [CW-1:0]                s1_col;
    logic [RW-1:0]                s1_row;
    logic signed [DATA_WIDTH-1:0] v_d1;
    logic signed [DATA_WIDTH-1:0] v_d2;
    logic signed [DATA_WIDTH-1:0] win_max;
    logic                         advance;
    logic                         win_ok;
    logic                         last_pos;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pxl_c = pxl_in;
`ifdef MAXPOOL_RELU_EN
        if (pxl_in[DATA_WIDTH-1]) begin
            pxl_c = '0;
        end
`else
`endif
    end

    pool_line_buffer #(
        .DEPTH      (WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (CW)
    ) u_lb1 (
        .clk   (clk),
        .en    (valid_in),
        .addr  (col),
        .wdata (pxl_c),
        .rdata (lb1_q)
    );

    pool_line_buffer #(
        .DEPTH      (WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (CW)
    ) u_lb0 (
        .clk   (clk),
        .en    (valid_in),
        .addr  (col),
        .wdata (lb1_q),
        .rdata (lb0_q)
    );

    assign col_max = DATA_WIDTH'(max3(widen(lb0_q), widen(lb1_q), widen(pxl_c)));

    // Stage 1: vertical max of the current column, tagged with its position.
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            s1_valid <= 1'b0;
            s1_v     <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else if (valid_in) begin
            s1_valid <= 1'b1;
            s1_v     <= col_max;
            s1_col   <= col;
            s1_row   <= row;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // A window is complete at even row/col positions at least one kernel span in.
    assign advance  = valid_in && s1_valid;
    assign win_ok   = (s1_row >= ROW_MIN) && !s1_row[0] && (s1_col >= COL_MIN) && !s1_col[0];
    assign last_pos = (s1_row == ROW_LAST) && (s1_col == COL_LAST);
    assign win_max  = DATA_WIDTH'(max3(widen(s1_v), widen(v_d1), widen(v_d2)));

    // Stage 2: horizontal window and registered output; pxl_out holds between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_d1       <= '0;
            v_d2       <= '0;
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= advance && win_ok;
            frame_done <= advance && win_ok && last_pos;
            if (advance) begin
                v_d1 <= s1_v;
                v_d2 <= v_d1;
                if (win_ok) begin
                    pxl_out <= win_max;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool3x3_s2.sv
// Self-checking bench: 5x5 directed scenarios and a randomized 149x149 frame,
// each compared against a direct 2D window-max reference model.
module tb_maxpool3x3_s2;

    typedef struct {
        logic signed [31:0] val;
        logic               fd;
        longint             c;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset = 1'b1;
    logic               vin5 = 1'b0;
    logic signed [31:0] px5 = '0;
    logic signed [31:0] pout5;
    logic               vout5, fd5;
    logic               vin149 = 1'b0;
    logic signed [31:0] px149 = '0;
    logic signed [31:0] pout149;
    logic               vout149, fd149;

    maxpool3x3_s2 #(.WIDTH(5), .HEIGHT(5), .DATA_WIDTH(32)) dut5 (
        .clk(clk), .reset(reset), .valid_in(vin5), .pxl_in(px5),
        .pxl_out(pout5), .valid_out(vout5), .frame_done(fd5)
    );

    maxpool3x3_s2 dut149 (
        .clk(clk), .reset(reset), .valid_in(vin149), .pxl_in(px149),
        .pxl_out(pout149), .valid_out(vout149), .frame_done(fd149)
    );

    int     n_checks = 0;
    int     n_fail = 0;
    longint cyc = 0;
    obs_t   obs5[$];
    obs_t   obs149[$];
    int     stray5 = 0;
    int     stray149 = 0;
    logic signed [31:0] img[];
    logic signed [31:0] exp_v[$];
    logic               exp_fd[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        obs_t o;
        #1;
        if (vout5) begin
            o.val = pout5; o.fd = fd5; o.c = cyc;
            obs5.push_back(o);
        end else if (fd5) stray5++;
        if (vout149) begin
            o.val = pout149; o.fd = fd149; o.c = cyc;
            obs149.push_back(o);
        end else if (fd149) stray149++;
    end

    function automatic logic signed [31:0] relu(input logic signed [31:0] x);
`ifdef MAXPOOL_RELU_EN
        return (x < 0) ? 32'sd0 : x;
`else
        return x;
`endif
    endfunction

    // Reference: direct max over each 3x3 window at stride 2 of the whole image.
    task automatic model_frame(input int w, input int h);
        int ow = (w - 3) / 2 + 1;
        int oh = (h - 3) / 2 + 1;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                logic signed [31:0] m = relu(img[(2 * oy) * w + 2 * ox]);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        if (relu(img[(2 * oy + i) * w + 2 * ox + j]) > m)
                            m = relu(img[(2 * oy + i) * w + 2 * ox + j]);
                exp_v.push_back(m);
                exp_fd.push_back(oy == oh - 1 && ox == ow - 1);
            end
        end
    endtask

    task automatic set_ramp5(input int offset);
        img = new[25];
        for (int k = 0; k < 25; k++) img[k] = 32'(k + offset);
    endtask

    task automatic push_exp(input logic signed [31:0] v, input logic fd);
        exp_v.push_back(v);
        exp_fd.push_back(fd);
    endtask

    task automatic send5(input logic signed [31:0] v, input bit gap);
        @(negedge clk);
        vin5 = 1'b1;
        px5  = v;
        if (gap) begin
            @(negedge clk);
            vin5 = 1'b0;
        end
    endtask

    task automatic flush5(input bit gap);
        send5(32'sd0, gap);
        send5(32'sd0, gap);
        @(negedge clk);
        vin5 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        vin5   = 1'b0;
        vin149 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        obs5.delete();
        obs149.delete();
        exp_v.delete();
        exp_fd.delete();
        stray5   = 0;
        stray149 = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (pout5 !== 32'sd0 || vout5 !== 1'b0 || fd5 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset5: got pxl=%0d v=%b fd=%b want 0 0 0", pout5, vout5, fd5);
        end
        n_checks++;
        if (pout149 !== 32'sd0 || vout149 !== 1'b0 || fd149 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset149: got pxl=%0d v=%b fd=%b want 0 0 0", pout149, vout149, fd149);
        end
    endtask

    task automatic test_ramp();
        longint trig = 0;
        do_reset();
        set_ramp5(0);
        for (int k = 0; k < 25; k++) begin
            send5(img[k], 1'b0);
            if (k == 12) trig = cyc;
        end
        flush5(1'b0);
        push_exp(12, 0); push_exp(14, 0); push_exp(22, 0); push_exp(24, 1);
        n_checks++;
        if (obs5.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL ramp_count: got %0d want %0d", obs5.size(), exp_v.size());
        end
        for (int i = 0; i < obs5.size() && i < exp_v.size(); i++) begin
            n_checks++;
            if (obs5[i].val !== exp_v[i] || obs5[i].fd !== exp_fd[i]) begin
                n_fail++;
                $display("FAIL ramp[%0d]: got %0d fd=%b want %0d fd=%b",
                         i, obs5[i].val, obs5[i].fd, exp_v[i], exp_fd[i]);
            end
        end
        if (obs5.size() > 0) begin
            n_checks++;
            if (obs5[0].c - trig != 2) begin
                n_fail++;
                $display("FAIL ramp_latency: got %0d cycles want 2", obs5[0].c - trig);
            end
        end
    endtask

    task automatic test_gapped();
        do_reset();
        set_ramp5(0);
        for (int k = 0; k < 25; k++) send5(img[k], 1'b1);
        flush5(1'b1);
        push_exp(12, 0); push_exp(14, 0); push_exp(22, 0); push_exp(24, 1);
        n_checks++;
        if (obs5.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL gap_count: got %0d want %0d", obs5.size(), exp_v.size());
        end
        for (int i = 0; i < obs5.size() && i < exp_v.size(); i++) begin
            n_checks++;
            if (obs5[i].val !== exp_v[i] || obs5[i].fd !== exp_fd[i]) begin
                n_fail++;
                $display("FAIL gap[%0d]: got %0d fd=%b want %0d fd=%b",
                         i, obs5[i].val, obs5[i].fd, exp_v[i], exp_fd[i]);
            end
        end
    endtask

    task automatic test_signed();
        do_reset();
        img = new[25];
        for (int k = 0; k < 25; k++) img[k] = -32'sd7;
        img[3 * 5 + 3] = -32'sd2;
        for (int k = 0; k < 25; k++) send5(img[k], 1'b0);
        flush5(1'b0);
`ifdef MAXPOOL_RELU_EN
        push_exp(0, 0); push_exp(0, 0); push_exp(0, 0); push_exp(0, 1);
`else
        push_exp(-7, 0); push_exp(-7, 0); push_exp(-7, 0); push_exp(-2, 1);
`endif
        n_checks++;
        if (obs5.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL signed_count: got %0d want %0d", obs5.size(), exp_v.size());
        end
        for (int i = 0; i < obs5.size() && i < exp_v.size(); i++) begin
            n_checks++;
            if (obs5[i].val !== exp_v[i] || obs5[i].fd !== exp_fd[i]) begin
                n_fail++;
                $display("FAIL signed[%0d]: got %0d fd=%b want %0d fd=%b",
                         i, obs5[i].val, obs5[i].fd, exp_v[i], exp_fd[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            set_ramp5(100 * f);
            for (int k = 0; k < 25; k++) send5(img[k], 1'b0);
        end
        flush5(1'b0);
        push_exp(12, 0);  push_exp(14, 0);  push_exp(22, 0);  push_exp(24, 1);
        push_exp(112, 0); push_exp(114, 0); push_exp(122, 0); push_exp(124, 1);
        n_checks++;
        if (obs5.size() != exp_v.size() || stray5 != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs %0d stray frame_done want %0d and 0",
                     obs5.size(), stray5, exp_v.size());
        end
        for (int i = 0; i < obs5.size() && i < exp_v.size(); i++) begin
            n_checks++;
            if (obs5[i].val !== exp_v[i] || obs5[i].fd !== exp_fd[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %0d fd=%b want %0d fd=%b",
                         i, obs5[i].val, obs5[i].fd, exp_v[i], exp_fd[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        set_ramp5(0);
        for (int k = 0; k < 16; k++) send5(img[k], 1'b0);
        @(negedge clk);
        vin5 = 1'b1;
        px5  = img[16];
        #2 reset = 1'b1;
        obs5.delete();
        #1;
        n_checks++;
        if (vout5 !== 1'b0 || pout5 !== 32'sd0 || fd5 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got pxl=%0d v=%b fd=%b want 0 0 0", pout5, vout5, fd5);
        end
        @(negedge clk);
        reset = 1'b0;
        vin5  = 1'b0;
        for (int k = 0; k < 25; k++) send5(img[k], 1'b0);
        flush5(1'b0);
        push_exp(12, 0); push_exp(14, 0); push_exp(22, 0); push_exp(24, 1);
        n_checks++;
        if (obs5.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d want %0d", obs5.size(), exp_v.size());
        end
        for (int i = 0; i < obs5.size() && i < exp_v.size(); i++) begin
            n_checks++;
            if (obs5[i].val !== exp_v[i] || obs5[i].fd !== exp_fd[i]) begin
                n_fail++;
                $display("FAIL midreset[%0d]: got %0d fd=%b want %0d fd=%b",
                         i, obs5[i].val, obs5[i].fd, exp_v[i], exp_fd[i]);
            end
        end
    endtask

    task automatic test_random_full();
        do_reset();
        img = new[149 * 149];
        for (int k = 0; k < 149 * 149; k++) img[k] = $urandom;
        model_frame(149, 149);
        for (int k = 0; k < 149 * 149 + 2; k++) begin
            @(negedge clk);
            vin149 = 1'b1;
            px149  = (k < 149 * 149) ? img[k] : 32'sd0;
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                vin149 = 1'b0;
            end
        end
        @(negedge clk);
        vin149 = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs149.size() != 5476 || exp_v.size() != 5476 || stray149 != 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d outputs %0d stray frame_done want 5476 and 0",
                     obs149.size(), stray149);
        end
        for (int i = 0; i < obs149.size() && i < exp_v.size(); i++) begin
            n_checks++;
            if (obs149[i].val !== exp_v[i] || obs149[i].fd !== exp_fd[i]) begin
                n_fail++;
                $display("FAIL rand[%0d]: got %0d fd=%b want %0d fd=%b",
                         i, obs149[i].val, obs149[i].fd, exp_v[i], exp_fd[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gapped();
        test_signed();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
